// File: rtl/midi_note_parser.sv
// Monophonic MIDI Note On/Off decoder for one channel (or omni), with running
// status and real-time byte passthrough; drives the note-to-ticks lookup.
//
// state | meaning
// IDLE  | no running status, data bytes dropped
// D1    | running status valid, awaiting first data byte
// D2    | first data byte latched, awaiting second
module midi_note_parser #(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter logic       OMNI    = 1'b0
) (
   input  logic       mclk,
   input  logic       rst_n,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic [7:0] midiNoteNumber,
   output logic [6:0] velocity,
   output logic       gate,
   output logic       note_strobe
);

   typedef enum logic [1:0] {IDLE, D1, D2} state_t;

   state_t     state, state_nxt;
   logic [3:0] rs_type, rs_type_nxt;
   logic       rs_match, rs_match_nxt;
   logic       expect2, expect2_nxt;
   logic [6:0] data1, data1_nxt;
   logic [6:0] note, note_nxt;
   logic [6:0] vel_nxt;
   logic       gate_nxt;
   logic       strobe_nxt;
   logic       is_note_msg;

   assign midiNoteNumber = {1'b0, note};
   assign is_note_msg    = rs_match && ((rs_type == 4'h8) || (rs_type == 4'h9));

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rs_type     <= 4'h0;
         rs_match    <= 1'b0;
         expect2     <= 1'b0;
         data1       <= 7'h00;
         note        <= 7'h00;
         velocity    <= 7'h00;
         gate        <= 1'b0;
         note_strobe <= 1'b0;
      end else begin
         state       <= state_nxt;
         rs_type     <= rs_type_nxt;
         rs_match    <= rs_match_nxt;
         expect2     <= expect2_nxt;
         data1       <= data1_nxt;
         note        <= note_nxt;
         velocity    <= vel_nxt;
         gate        <= gate_nxt;
         note_strobe <= strobe_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      rs_type_nxt  = rs_type;
      rs_match_nxt = rs_match;
      expect2_nxt  = expect2;
      data1_nxt    = data1;
      note_nxt     = note;
      vel_nxt      = velocity;
      gate_nxt     = gate;
      strobe_nxt   = 1'b0;

      if (rx_valid) begin
         if (rx_byte[7:3] == 5'b11111) begin
            // real-time bytes are transparent, even mid-message
         end else if (rx_byte[7:4] == 4'hF) begin
            state_nxt    = IDLE;
            rs_type_nxt  = 4'h0;
            rs_match_nxt = 1'b0;
            expect2_nxt  = 1'b0;
         end else if (rx_byte[7]) begin
            state_nxt    = D1;
            rs_type_nxt  = rx_byte[7:4];
            rs_match_nxt = OMNI || (rx_byte[3:0] == CHANNEL);
            expect2_nxt  = !((rx_byte[7:4] == 4'hC) || (rx_byte[7:4] == 4'hD));
         end else begin
            case (state)
               D1: begin
                  data1_nxt = rx_byte[6:0];
                  state_nxt = expect2 ? D2 : D1;
               end
               D2: begin
                  state_nxt = D1;
                  if (is_note_msg && (rs_type == 4'h9) && (rx_byte[6:0] != 7'h00)) begin
                     note_nxt   = data1;
                     vel_nxt    = rx_byte[6:0];
                     gate_nxt   = 1'b1;
                     strobe_nxt = 1'b1;
                  end else if (is_note_msg && gate && (data1 == note)) begin
                     // release only the most recent note (last-note priority)
                     gate_nxt   = 1'b0;
                     strobe_nxt = 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser: byte sequences with hand-computed
// note/velocity/gate results and strobe counts, on a channel-0 and an omni instance.
module tb_midi_note_parser;

   logic       mclk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;

   logic [7:0] note_a, note_b;
   logic [6:0] vel_a, vel_b;
   logic       gate_a, gate_b;
   logic       strobe_a, strobe_b;

   int checks = 0;
   int failures = 0;
   int strobes_a = 0;
   int strobes_b = 0;
   int s0;

   always #5 mclk = ~mclk;

   midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
      .mclk(mclk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .midiNoteNumber(note_a), .velocity(vel_a), .gate(gate_a), .note_strobe(strobe_a)
   );

   midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_omni (
      .mclk(mclk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .midiNoteNumber(note_b), .velocity(vel_b), .gate(gate_b), .note_strobe(strobe_b)
   );

   always @(negedge mclk) begin
      if (strobe_a) strobes_a++;
      if (strobe_b) strobes_b++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge mclk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge mclk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(negedge mclk);
   endtask

   task automatic expect_a(input string tag, input logic [7:0] n, input logic [6:0] v,
                           input logic g, input int nstrobe);
      settle();
      check({tag, "_note"}, note_a, n);
      check({tag, "_vel"}, vel_a, v);
      check({tag, "_gate"}, gate_a, g);
      check({tag, "_strobes"}, strobes_a - s0, nstrobe);
      s0 = strobes_a;
   endtask

   initial begin
      repeat (3) @(negedge mclk);
      check("rst_note", note_a, 8'h00);
      check("rst_vel", vel_a, 7'h00);
      check("rst_gate", gate_a, 1'b0);
      check("rst_strobe", strobe_a, 1'b0);
      rst_n = 1'b1;
      s0 = strobes_a;

      // basic note on/off
      send(8'h90); send(8'h45); send(8'h64);
      expect_a("on45", 8'h45, 7'd100, 1'b1, 1);
      send(8'h80); send(8'h45); send(8'h00);
      expect_a("off45", 8'h45, 7'd100, 1'b0, 1);

      // running status, stale release ignored
      send(8'h90); send(8'h3C); send(8'h40);
      expect_a("rs_on3c", 8'h3C, 7'h40, 1'b1, 1);
      send(8'h3E); send(8'h41);
      expect_a("rs_on3e", 8'h3E, 7'h41, 1'b1, 1);
      send(8'h3C); send(8'h00);
      expect_a("rs_stale_off", 8'h3E, 7'h41, 1'b1, 0);

      // real-time byte between data bytes
      send(8'h90); send(8'h40); send(8'hF8); send(8'h7F);
      expect_a("rt_on40", 8'h40, 7'h7F, 1'b1, 1);
      send(8'h40); send(8'h20);
      expect_a("retrig40", 8'h40, 7'h20, 1'b1, 1);

      // channel filter and single-data-byte program change
      send(8'h91); send(8'h41); send(8'h41);
      expect_a("ch1_ignored", 8'h40, 7'h20, 1'b1, 0);
      send(8'hC0); send(8'h05); send(8'h90); send(8'h30); send(8'h22);
      expect_a("pc_then_on30", 8'h30, 7'h22, 1'b1, 1);
      send(8'h9F); send(8'h40); send(8'h40);
      expect_a("ch15_ignored", 8'h30, 7'h22, 1'b1, 0);
      check("omni_note", note_b, 8'h40);
      check("omni_vel", vel_b, 7'h40);
      check("omni_gate", gate_b, 1'b1);

      // status byte in D2 aborts pending message
      send(8'h90); send(8'h50); send(8'h90); send(8'h51); send(8'h33);
      expect_a("abort_on51", 8'h51, 7'h33, 1'b1, 1);
      send(8'h80); send(8'h51); send(8'h40);
      expect_a("off51_vel", 8'h51, 7'h33, 1'b0, 1);

      // sysex clears running status
      send(8'h90); send(8'h40); send(8'h40);
      expect_a("sx_on40", 8'h40, 7'h40, 1'b1, 1);
      send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h41); send(8'h40);
      expect_a("sx_trailing", 8'h40, 7'h40, 1'b1, 0);

      // asynchronous reset mid-message
      send(8'h90); send(8'h40);
      @(negedge mclk);
      #2 rst_n = 1'b0;
      #1;
      check("async_note", note_a, 8'h00);
      check("async_gate", gate_a, 1'b0);
      check("async_vel", vel_a, 7'h00);
      @(negedge mclk);
      rst_n = 1'b1;
      s0 = strobes_a;
      send(8'h40);
      expect_a("post_rst_data", 8'h00, 7'h00, 1'b0, 0);
      send(8'h90); send(8'h50); send(8'h10);
      expect_a("post_rst_on50", 8'h50, 7'h10, 1'b1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
